router_fsm: RTL and testbench

Control state machine for the 1x3 router.
- Sequences the register/parity datapath and the three destination FIFOs for each incoming packet.
- Decodes the 2-bit destination address from the header byte and waits for the destination FIFO to drain.
- Drives the per-state strobes the datapath uses for header, payload, full-hold and parity handling, and the busy back-pressure to the source.

---
 rtl/router_fsm.sv | 199 +++++++++++++++++++
 tb/tb_router_fsm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// router_fsm: control state machine for the 1x3 packet router.
// Sequences header decode, payload load, FIFO-full hold and parity check
// for each packet, and drives the datapath strobes and the busy stall.
//
// Optional feature macro: ROUTER_FSM_DROP_EN
//   When defined, packets to address 3 are discarded in a DROP_PACKET
//   state and pkt_drop pulses once as the packet ends. When undefined,
//   address 3 is simply never accepted and pkt_drop is tied low.
//
// Parameters:
//   ONEHOT  0 = binary state code, 1 = one-hot state code (same behaviour)
//
// Ports:
//   clock              system clock, rising edge
//   resetn             asynchronous active-low reset
//   pkt_valid          source has a packet byte on data_in
//   data_in[1:0]       destination address field of the header byte
//   fifo_full          selected destination FIFO is full
//   fifo_empty_0/1/2   destination FIFO k is empty
//   soft_reset_0/1/2   destination FIFO k timed out
//   parity_done        datapath has captured the packet parity
//   low_pkt_valid      datapath saw pkt_valid drop during a load
//   busy               stall the source
//   detect_add         in DECODE_ADDRESS
//   lfd_state          in LOAD_FIRST_DATA
//   ld_state           in LOAD_DATA
//   laf_state          in LOAD_AFTER_FULL
//   full_state         in FIFO_FULL_STATE
//   write_enb_reg      datapath byte is written to the FIFO this cycle
//   rst_int_reg        in CHECK_PARITY_ERROR
//   pkt_drop           one-cycle pulse after a dropped packet ends
module router_fsm #(
  parameter int ONEHOT = 0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       pkt_drop
);

`ifdef ROUTER_FSM_DROP_EN
  localparam int NS = 9;
`else
  localparam int NS = 8;
`endif
  localparam int SW = (ONEHOT != 0) ? NS : ((NS > 8) ? 4 : 3);

  function automatic logic [SW-1:0] enc(input int idx);
    if (ONEHOT != 0) return SW'(1) << idx;
    else             return SW'(idx);
  endfunction

  function automatic logic is_st(input logic [SW-1:0] s, input logic [SW-1:0] code);
    if (ONEHOT != 0) return |(s & code);
    else             return s == code;
  endfunction

  localparam logic [SW-1:0] ST_DA  = enc(0);
  localparam logic [SW-1:0] ST_LFD = enc(1);
  localparam logic [SW-1:0] ST_LD  = enc(2);
  localparam logic [SW-1:0] ST_LP  = enc(3);
  localparam logic [SW-1:0] ST_FFS = enc(4);
  localparam logic [SW-1:0] ST_LAF = enc(5);
  localparam logic [SW-1:0] ST_WTE = enc(6);
  localparam logic [SW-1:0] ST_CPE = enc(7);
`ifdef ROUTER_FSM_DROP_EN
  localparam logic [SW-1:0] ST_DROP = enc(8);
`endif

  logic [SW-1:0] state, state_nxt;
  logic [1:0]    addr;
  logic st_da, st_lfd, st_ld, st_lp, st_ffs, st_laf, st_wte, st_cpe, st_drop;
  logic empty_sel, soft_sel;

  assign st_da  = is_st(state, ST_DA);
  assign st_lfd = is_st(state, ST_LFD);
  assign st_ld  = is_st(state, ST_LD);
  assign st_lp  = is_st(state, ST_LP);
  assign st_ffs = is_st(state, ST_FFS);
  assign st_laf = is_st(state, ST_LAF);
  assign st_wte = is_st(state, ST_WTE);
  assign st_cpe = is_st(state, ST_CPE);
`ifdef ROUTER_FSM_DROP_EN
  assign st_drop = is_st(state, ST_DROP);
`else
  assign st_drop = 1'b0;
`endif

  // Empty flag and soft reset of the port latched at header time.
  always_comb begin
    empty_sel = 1'b0;
    soft_sel  = 1'b0;
    case (addr)
      2'd0: begin empty_sel = fifo_empty_0; soft_sel = soft_reset_0; end
      2'd1: begin empty_sel = fifo_empty_1; soft_sel = soft_reset_1; end
      2'd2: begin empty_sel = fifo_empty_2; soft_sel = soft_reset_2; end
      default: begin empty_sel = 1'b0; soft_sel = 1'b0; end
    endcase
  end

  // State register and header address latch
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_DA;
      addr  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (st_da && pkt_valid) addr <= data_in;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (st_da) begin
      if (pkt_valid) begin
        case (data_in)
          2'd0: state_nxt = fifo_empty_0 ? ST_LFD : ST_WTE;
          2'd1: state_nxt = fifo_empty_1 ? ST_LFD : ST_WTE;
          2'd2: state_nxt = fifo_empty_2 ? ST_LFD : ST_WTE;
`ifdef ROUTER_FSM_DROP_EN
          default: state_nxt = ST_DROP;
`else
          default: state_nxt = ST_DA;
`endif
        endcase
      end
    end else if (st_lfd) begin
      state_nxt = ST_LD;
    end else if (st_ld) begin
      // A full FIFO takes precedence over the end of the packet.
      if (fifo_full)       state_nxt = ST_FFS;
      else if (!pkt_valid) state_nxt = ST_LP;
    end else if (st_ffs) begin
      if (!fifo_full) state_nxt = ST_LAF;
    end else if (st_laf) begin
      if (parity_done)        state_nxt = ST_DA;
      else if (low_pkt_valid) state_nxt = ST_LP;
      else                    state_nxt = ST_LD;
    end else if (st_lp) begin
      state_nxt = ST_CPE;
    end else if (st_cpe) begin
      state_nxt = fifo_full ? ST_FFS : ST_DA;
    end else if (st_wte) begin
      if (empty_sel) state_nxt = ST_LFD;
    end else if (st_drop) begin
      if (!pkt_valid) state_nxt = ST_DA;
    end else begin
      // Unreachable codes recover to the idle state.
      state_nxt = ST_DA;
    end
    // Timed-out destination aborts the packet; a dropped packet has no
    // destination so it is unaffected.
    if (soft_sel && !st_da && !st_drop) state_nxt = ST_DA;
  end

  // Output decode, registered state only
  always_comb begin
    detect_add    = st_da;
    lfd_state     = st_lfd;
    ld_state      = st_ld;
    laf_state     = st_laf;
    full_state    = st_ffs;
    write_enb_reg = st_ld | st_lp | st_laf;
    rst_int_reg   = st_cpe;
    busy          = !(st_da | st_ld | st_drop);
  end

`ifdef ROUTER_FSM_DROP_EN
  // Registered so the pulse coincides with the DA cycle that ends the drop.
  logic drop_q;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) drop_q <= 1'b0;
    else         drop_q <= st_drop && !pkt_valid;
  end
  assign pkt_drop = drop_q;
`else
  assign pkt_drop = 1'b0;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed stimulus with a scoreboard queue of expected
// output vectors, checked by an independent monitor after each clock edge.
module tb_router_fsm;

  logic       clock, resetn, pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_pkt_valid;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, pkt_drop;

  router_fsm #(.ONEHOT(0)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .pkt_drop(pkt_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy, pkt_drop}
  localparam logic [8:0] E_DA   = 9'b1_0000_0000;
  localparam logic [8:0] E_LFD  = 9'b0_1000_0010;
  localparam logic [8:0] E_LD   = 9'b0_0100_1000;
  localparam logic [8:0] E_LP   = 9'b0_0000_1010;
  localparam logic [8:0] E_FFS  = 9'b0_0001_0010;
  localparam logic [8:0] E_LAF  = 9'b0_0010_1010;
  localparam logic [8:0] E_WTE  = 9'b0_0000_0010;
  localparam logic [8:0] E_CPE  = 9'b0_0000_0110;
`ifdef ROUTER_FSM_DROP_EN
  localparam logic [8:0] E_A3   = 9'b0_0000_0000;
  localparam logic [8:0] E_A3END = 9'b1_0000_0001;
`else
  localparam logic [8:0] E_A3   = E_DA;
  localparam logic [8:0] E_A3END = E_DA;
`endif

  logic [8:0] act;
  assign act = {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy, pkt_drop};

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] q_v[$];
  string      q_n[$];

  task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // Monitor: every edge that has a pending expectation is compared.
  always @(posedge clock) begin
    #1;
    if (q_v.size() > 0) begin
      logic [8:0] e;
      string      n;
      e = q_v.pop_front();
      n = q_n.pop_front();
      check(n, act, e);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic pv, input logic [1:0] din, input logic full,
                      input logic [2:0] fe, input logic [2:0] sr,
                      input logic pd, input logic lpv,
                      input logic [8:0] e, input string nm);
    @(negedge clock);
    pkt_valid = pv; data_in = din; fifo_full = full;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = fe;
    {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
    parity_done = pd; low_pkt_valid = lpv;
    q_v.push_back(e);
    q_n.push_back(nm);
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    @(negedge clock);
    check("reset_state", act, E_DA);
    resetn = 1'b1;

    // Normal packet to address 1
    step(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_LFD, "norm_lfd");
    step(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_LD,  "norm_ld1");
    step(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_LD,  "norm_ld2");
    step(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_LD,  "norm_ld3");
    step(0, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_LP,  "norm_lp");
    step(0, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_CPE, "norm_cpe");
    step(0, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_DA,  "norm_da");
    step(0, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_DA,  "idle_no_pv");

    // Asynchronous reset in the middle of a load, away from any edge
    step(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LFD, "rst_pre_lfd");
    step(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LD,  "rst_pre_ld");
    @(negedge clock);
    pkt_valid = 1'b0;
    #2 resetn = 1'b0;
    #1 check("async_reset", act, E_DA);
    resetn = 1'b1;

    // Destination not empty: wait on the latched address only
    step(1, 2'd2, 0, 3'b000, 3'b000, 0, 0, E_WTE, "wte_1");
    for (int i = 2; i <= 5; i++)
      step(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_WTE, $sformatf("wte_%0d", i));
    step(1, 2'd0, 0, 3'b100, 3'b000, 0, 0, E_LFD, "wte_lfd");
    step(1, 2'd0, 0, 3'b100, 3'b000, 0, 0, E_LD,  "wte_ld");
    step(0, 2'd0, 0, 3'b100, 3'b000, 0, 0, E_LP,  "wte_lp");
    step(0, 2'd0, 1, 3'b100, 3'b000, 0, 0, E_CPE, "lp_to_cpe_full");
    step(0, 2'd0, 1, 3'b100, 3'b000, 0, 0, E_FFS, "cpe_full_ffs");
    step(0, 2'd0, 0, 3'b100, 3'b000, 0, 0, E_LAF, "cpe_laf");
    step(0, 2'd0, 0, 3'b100, 3'b000, 1, 0, E_DA,  "laf_parity_da");

    // Full during load on address 0, then soft resets while in FFS
    step(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LFD, "full_lfd");
    step(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LD,  "full_ld");
    step(0, 2'd0, 1, 3'b001, 3'b000, 0, 0, E_FFS, "ffs_wins_1");
    step(0, 2'd0, 1, 3'b001, 3'b000, 0, 0, E_FFS, "ffs_2");
    step(0, 2'd0, 1, 3'b001, 3'b000, 0, 0, E_FFS, "ffs_3");
    step(0, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LAF, "ffs_laf");
    step(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, E_LD,  "laf_ld");
    step(1, 2'd0, 1, 3'b001, 3'b000, 0, 0, E_FFS, "ld_ffs");
    step(1, 2'd0, 1, 3'b001, 3'b010, 0, 0, E_FFS, "sr1_ignored");
    step(1, 2'd0, 1, 3'b001, 3'b001, 0, 0, E_DA,  "sr0_abort");

    // LAF with low_pkt_valid goes to parity
    step(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_LFD, "lpv_lfd");
    step(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_LD,  "lpv_ld");
    step(1, 2'd1, 1, 3'b010, 3'b000, 0, 0, E_FFS, "lpv_ffs");
    step(1, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_LAF, "lpv_laf");
    step(0, 2'd1, 0, 3'b010, 3'b000, 0, 1, E_LP,  "laf_lpv_lp");
    step(0, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_CPE, "lpv_cpe");
    step(0, 2'd1, 0, 3'b010, 3'b000, 0, 0, E_DA,  "lpv_da");

    // Address 3 for six cycles, soft resets asserted in the middle
    for (int i = 1; i <= 6; i++)
      step(1, 2'd3, 0, 3'b111, (i == 3) ? 3'b111 : 3'b000, 0, 0, E_A3,
           $sformatf("addr3_%0d", i));
    step(0, 2'd3, 0, 3'b111, 3'b000, 0, 0, E_A3END, "addr3_end");
    step(0, 2'd3, 0, 3'b111, 3'b000, 0, 0, E_DA,    "addr3_after");

    begin
      int budget;
      budget = 0;
      while (q_v.size() > 0 && budget < 20) begin
        @(posedge clock);
        budget++;
      end
      #2;
      n_checks++;
      if (q_v.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expectations left, required 0", q_v.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
